// File: rtl/pc_fetch_sequencer_pkg.sv
// rtl/pc_fetch_sequencer_pkg.sv - shared types, constants and PC masking helper for the fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Keep only word-aligned bits inside the instruction-memory window.
    function automatic logic [31:0] pc_mask(input logic [31:0] addr, input int addr_bits);
        logic [31:0] m;
        m = '0;
        for (int i = 2; i < 32; i++) begin
            if (i < addr_bits) begin
                m[i] = 1'b1;
            end
        end
        return addr & m;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// rtl/pc_fetch_sequencer_if.sv - valid/ready PC hand-off between fetch sequencer and CPU_V1
interface pc_fetch_sequencer_if;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        pc_ready;

    modport master (output pc_out, output pc_valid, input pc_ready);
    modport slave  (input pc_out, input pc_valid, output pc_ready);
endinterface

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - program counter generator with redirect, halt/resume and fetch counter
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ADDR_BITS = 10,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    pc_fetch_sequencer_if.master pc_bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] fetch_count,
    output logic                 misalign_err
);
    import fetch_pkg::*;

    localparam logic [31:0] START_PC = pc_mask(RESET_PC, ADDR_BITS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_t         state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 misalign_q, misalign_d;
    logic                 accept;
    logic [31:0]          pc_inc;

    assign accept = (state_q == RUN) && pc_bus.pc_ready;
    assign pc_inc = pc_mask(pc_q + PC_STEP, ADDR_BITS);

    // State register; reset aborts any operation immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start leaves IDLE/HALTED, halt_req leaves RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (halt_req) state_d = HALTED;
            HALTED:  if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Next-PC priority mux (halt > redirect > accept > hold) with the counter alongside.
    always_comb begin
        pc_d       = pc_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        case (state_q)
            IDLE: begin
                if (start) pc_d = START_PC;
            end
            RUN: begin
                if (halt_req) begin
                    // An accept on the halt cycle makes the resume point the next instruction.
                    if (accept) begin
                        pc_d    = pc_inc;
                        count_d = count_q + CNT_ONE;
                    end
                end else if (redirect_valid) begin
                    // Redirect wins regardless of pc_ready; an unaccepted PC is dropped uncounted.
                    pc_d = pc_mask(redirect_pc, ADDR_BITS);
                    if (accept) count_d = count_q + CNT_ONE;
                    if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
                end else if (accept) begin
                    pc_d    = pc_inc;
                    count_d = count_q + CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    // PC, counter and sticky misalignment flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= START_PC;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Outputs come straight from registers, so there is no input-to-output path.
    always_comb begin
        pc_bus.pc_out   = pc_q;
        pc_bus.pc_valid = (state_q == RUN);
        busy            = (state_q == RUN);
        fetch_count     = count_q;
        misalign_err    = misalign_q;
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - directed self-checking bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        busy;
    logic [15:0] fetch_count;
    logic        misalign_err;

    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_sequencer_if pc_bus ();

    pc_fetch_sequencer #(
        .RESET_PC  (32'h0000_0000),
        .ADDR_BITS (10),
        .CNT_WIDTH (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_bus         (pc_bus.master),
        .busy           (busy),
        .fetch_count    (fetch_count),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic valid,
                             input logic [31:0] cnt, input logic mis);
        check_eq({tag, ".pc_out"}, pc_bus.pc_out, pc);
        check_eq({tag, ".pc_valid"}, {31'b0, pc_bus.pc_valid}, {31'b0, valid});
        check_eq({tag, ".busy"}, {31'b0, busy}, {31'b0, valid});
        check_eq({tag, ".fetch_count"}, {16'b0, fetch_count}, cnt);
        check_eq({tag, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, mis});
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        pc_bus.pc_ready = 1'b0;

        // Reset state
        cyc(); cyc();
        check_all("reset", 32'h0, 1'b0, 0, 1'b0);
        reset = 1'b1;
        cyc();
        check_all("idle", 32'h0, 1'b0, 0, 1'b0);

        // 1: start and sequential stepping
        start = 1'b1; cyc(); start = 1'b0;
        check_all("start", 32'h0, 1'b1, 0, 1'b0);
        pc_bus.pc_ready = 1'b1;
        cyc(); check_all("seq1", 32'h4, 1'b1, 1, 1'b0);
        cyc(); check_all("seq2", 32'h8, 1'b1, 2, 1'b0);

        // 2: backpressure at 0x8
        pc_bus.pc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); check_all("stall", 32'h8, 1'b1, 2, 1'b0);
        end
        pc_bus.pc_ready = 1'b1;
        cyc(); check_all("seq3", 32'hC, 1'b1, 3, 1'b0);
        cyc(); check_all("seq4", 32'h10, 1'b1, 4, 1'b0);

        // 3: redirect without accept, then misaligned redirect
        pc_bus.pc_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cyc(); check_all("redir", 32'h40, 1'b1, 4, 1'b0);
        redirect_pc = 32'h42;
        cyc(); check_all("redir_mis", 32'h40, 1'b1, 4, 1'b1);
        redirect_valid = 1'b0;
        repeat (10) cyc();
        check_all("mis_sticky", 32'h40, 1'b1, 4, 1'b1);

        // Redirect with accept is counted
        redirect_valid = 1'b1; redirect_pc = 32'h20; pc_bus.pc_ready = 1'b1;
        cyc(); check_all("redir_acc", 32'h20, 1'b1, 5, 1'b1);
        redirect_valid = 1'b0;

        // 4: halt with accept, redirect ignored while halted, resume
        halt_req = 1'b1;
        cyc(); check_all("halt_acc", 32'h24, 1'b0, 6, 1'b1);
        halt_req = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        cyc(); cyc(); check_all("halted_hold", 32'h24, 1'b0, 6, 1'b1);
        redirect_valid = 1'b0; pc_bus.pc_ready = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        check_all("resume", 32'h24, 1'b1, 6, 1'b1);

        // 5: wrap at window top, masking of high redirect target
        redirect_valid = 1'b1; redirect_pc = 32'h3FC;
        cyc(); check_all("redir_top", 32'h3FC, 1'b1, 6, 1'b1);
        redirect_valid = 1'b0; pc_bus.pc_ready = 1'b1;
        cyc(); check_all("wrap", 32'h0, 1'b1, 7, 1'b1);
        pc_bus.pc_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_F404;
        cyc(); check_all("redir_mask", 32'h4, 1'b1, 7, 1'b1);
        redirect_valid = 1'b0;

        // Halt without accept keeps pc_out; start while running ignored
        start = 1'b1; cyc(); start = 1'b0;
        check_all("start_in_run", 32'h4, 1'b1, 7, 1'b1);
        halt_req = 1'b1;
        cyc(); check_all("halt_noacc", 32'h4, 1'b0, 7, 1'b1);
        halt_req = 1'b0; start = 1'b1; cyc(); start = 1'b0;
        pc_bus.pc_ready = 1'b1;
        cyc(); check_all("resume2", 32'h8, 1'b1, 8, 1'b1);

        // 6: asynchronous reset between clock edges
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 1'b0, 0, 1'b0);
        cyc(); reset = 1'b1;
        repeat (3) cyc();
        check_all("post_rst_idle", 32'h0, 1'b0, 0, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        check_all("restart", 32'h0, 1'b1, 0, 1'b0);
        cyc(); check_all("restart_acc", 32'h4, 1'b1, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Upstream stage of CPU_V1: generates the 32-bit program counter that drives CPU_V1's pc input.
- Provides valid/ready hand-off, sequential +4 stepping, branch/jump redirect, halt/resume, wrap within the instruction-memory window, and an accepted-fetch counter for debug.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; start address for a cold start.
ADDR_BITS, 10, byte-address width of the instruction memory. pc_out[31:ADDR_BITS] is always 0; increments wrap modulo 2^ADDR_BITS.
CNT_WIDTH, 16, width of fetch_count.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
start  input  1  IDLE: begin at RESET_PC. HALTED: resume at the held pc_out.
halt_req  input  1  stop issuing PCs.
redirect_valid  input  1  branch/jump taken this cycle.
redirect_pc  input  32  redirect target byte address.
pc_ready  input  1  downstream (CPU_V1) accepts pc_out this cycle.
pc_out  output  32  current PC presented downstream.
pc_valid  output  1  pc_out is valid.
busy  output  1  1 when state is RUN.
fetch_count  output  CNT_WIDTH  number of accepted PCs; wraps.
misalign_err  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, pc_out=RESET_PC masked to ADDR_BITS, pc_valid=0, fetch_count=0, misalign_err=0.
  - Asserting reset mid-operation aborts immediately; no partial update survives.
- Handshake: a PC is accepted when pc_valid && pc_ready.
  - While pc_valid=1 and pc_ready=0, pc_out is held stable.
  - pc_valid never drops without a halt or reset.
- Masking: pc_out and all next-PC values are ANDed with the mask {zeros[31:ADDR_BITS], ones[ADDR_BITS-1:2], 2'b00}.
- States:
  - IDLE: pc_valid=0. On start, next cycle: RUN, pc_valid=1, pc_out=RESET_PC. Other inputs are ignored in IDLE.
  - RUN: pc_valid=1. Per-cycle priority is halt_req > redirect_valid > accept (see below).
  - HALTED: pc_valid=0, pc_out held. On start, next cycle: RUN, pc_valid=1, pc_out unchanged. redirect_valid is ignored in HALTED.
- RUN priority, evaluated each cycle:
  1. halt_req: next cycle HALTED, pc_valid=0. If an accept also happens this cycle, fetch_count increments and pc_out advances by 4 (the resume point is the next instruction); otherwise pc_out is unchanged.
  2. redirect_valid: next pc_out = masked redirect_pc, independent of pc_ready. If an accept also happens this cycle, fetch_count increments; otherwise the un-accepted PC is discarded and not counted. If redirect_pc[1:0] != 0, set misalign_err=1.
  3. accept only: pc_out <= (pc_out + 4) wrapped to ADDR_BITS, fetch_count++.
  4. no accept: hold.
- Latency: one cycle from any control input to pc_out/pc_valid. There is no combinational path from inputs to outputs.
- Wrap: with ADDR_BITS=10, an accept at pc_out=32'h3FC gives next pc_out=32'h000. fetch_count wraps from all-ones to 0.
- start while in RUN is ignored. halt_req while in HALTED is ignored.

Decomposition:
- Package fetch_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t
  - localparam PC_STEP = 4
  - function pc_mask(addr, ADDR_BITS)
- Single module; no sub-module is needed. Next-PC selection is one priority mux feeding the pc register, with the counter alongside.

Test Plan:
1. Reset then start, pc_ready=1 held for 4 cycles -> pc_out sequence 0x0, 0x4, 0x8, 0xC; fetch_count=4; busy=1.
2. Backpressure: pc_ready=0 for 3 cycles at pc_out=0x8 -> pc_out stays 0x8 and pc_valid stays 1; fetch_count does not change until pc_ready returns to 1.
3. Redirect: redirect_valid=1 with redirect_pc=0x40 and pc_ready=0 at pc_out=0x10 -> next pc_out=0x40; 0x10 is not counted. Repeat with redirect_pc=0x42 -> pc_out=0x40 and misalign_err=1, still set after 10 more cycles.
4. Halt/resume: halt_req together with an accept at pc_out=0x20 -> HALTED, pc_valid=0, pc_out=0x24. Next, start -> pc_valid=1 with pc_out=0x24.
5. Wrap: ADDR_BITS=10, redirect to 0x3FC, accept -> pc_out=0x000. Also redirect_pc=0xFFFF_F404 -> pc_out=0x004.
6. Asynchronous reset asserted mid-RUN between clock edges -> pc_valid=0, pc_out=RESET_PC, fetch_count=0, misalign_err=0 immediately, without waiting for a clock edge; the block stays in IDLE until start.
